// File: rtl/str_window_if.sv
// Byte-stream in / sliding-window out bundle for str_window.
// The slave modport is the window builder; the master modport is the
// side that feeds bytes and consumes windows.
interface str_window_if #(
    parameter int BYTE_W   = 8,
    parameter int STR_SIZE = 20,
    parameter int POS_W    = 16
);
    logic [BYTE_W-1:0]                data_i;
    logic                             valid_i;
    logic                             sop_i;
    logic                             eop_i;
    logic                             ready_o;
    logic [STR_SIZE-1:0][BYTE_W-1:0]  win_o;
    logic                             win_valid_o;
    logic                             win_ready_i;
    logic [POS_W-1:0]                 win_pos_o;
    logic                             win_last_o;
    logic                             drop_o;

    modport slave (
        input  data_i, valid_i, sop_i, eop_i, win_ready_i,
        output ready_o, win_o, win_valid_o, win_pos_o, win_last_o, drop_o
    );

    modport master (
        output data_i, valid_i, sop_i, eop_i, win_ready_i,
        input  ready_o, win_o, win_valid_o, win_pos_o, win_last_o, drop_o
    );
endinterface

// File: rtl/str_window.sv
// Sliding window builder feeding the bloom-filter CRC hash.
// Handshakes: on both sides a transfer happens on a clock edge where
// valid and ready are both 1. Input: valid_i/ready_o, ready_o is
// combinational and only drops while a window is waiting downstream.
// Output: win_valid_o/win_ready_i; while win_valid_o is 1 and win_ready_i
// is 0 the window, its offset and its last flag are held unchanged.
// Window element 0 is the oldest byte, element STR_SIZE-1 the newest.
module str_window #(
    parameter int BYTE_W   = 8,
    parameter int STR_SIZE = 20,
    parameter int POS_W    = 16
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    str_window_if.slave    bus,
    output logic           dbg_in_pkt_o
);
    localparam int FILL_W = $clog2(STR_SIZE + 1);
    localparam logic [FILL_W-1:0] FULL    = FILL_W'(STR_SIZE);
    localparam logic [FILL_W-1:0] ONE     = FILL_W'(1);
    localparam logic [POS_W-1:0]  POS_MAX = '1;

    typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

    state_t                            state_q;
    logic [FILL_W-1:0]                 fill_q;
    logic [FILL_W-1:0]                 fill_nxt;
    logic                              emitted_q;
    logic                              emitted_eff;
    // Holds the newest STR_SIZE-1 bytes; the incoming byte completes a window.
    logic [STR_SIZE-2:0][BYTE_W-1:0]   hist_q;
    logic [STR_SIZE-1:0][BYTE_W-1:0]   shifted;
    logic [STR_SIZE-1:0][BYTE_W-1:0]   win_q;
    logic                              win_valid_q;
    logic [POS_W-1:0]                  win_pos_q;
    logic [POS_W-1:0]                  pos_nxt;
    logic                              win_last_q;
    logic                              drop_q;
    logic                              drop_nxt;
    logic                              ready;
    logic                              accept;
    logic                              in_use;
    logic                              emit;

    assign ready            = !win_valid_q || bus.win_ready_i;
    assign bus.ready_o      = ready;
    assign bus.win_o        = win_q;
    assign bus.win_valid_o  = win_valid_q;
    assign bus.win_pos_o    = win_pos_q;
    assign bus.win_last_o   = win_last_q;
    assign bus.drop_o       = drop_q;
    assign dbg_in_pkt_o     = (state_q == IN_PKT);

    // Next-state decode for one accepted byte: fill, emit, offset and drop.
    always_comb begin
        accept      = bus.valid_i && ready;
        in_use      = accept && (state_q == IN_PKT || bus.sop_i);
        // A sop byte starts a fresh packet, so the old emitted flag no longer counts.
        emitted_eff = emitted_q && !bus.sop_i;
        fill_nxt    = fill_q;
        if (bus.sop_i)
            fill_nxt = ONE;
        else if (fill_q != FULL)
            fill_nxt = fill_q + ONE;
        emit        = in_use && (fill_nxt == FULL);
        shifted     = {bus.data_i, hist_q};
        pos_nxt     = '0;
        if (emitted_eff)
            pos_nxt = (win_pos_q == POS_MAX) ? POS_MAX : win_pos_q + 1'b1;
        // Abort of a window-less packet, or a window-less packet reaching eop.
        drop_nxt    = (accept && bus.sop_i && state_q == IN_PKT && !emitted_q)
                   || (in_use && bus.eop_i && !emit && !emitted_eff);
    end

    // Packet FSM, shift history, output window register and drop pulse.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            fill_q      <= '0;
            emitted_q   <= 1'b0;
            hist_q      <= '0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
            win_pos_q   <= '0;
            win_last_q  <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            if (in_use) begin
                state_q   <= bus.eop_i ? IDLE : IN_PKT;
                fill_q    <= fill_nxt;
                emitted_q <= emitted_eff || emit;
                hist_q    <= shifted[STR_SIZE-1:1];
            end
            if (emit) begin
                win_q       <= shifted;
                win_valid_q <= 1'b1;
                win_pos_q   <= pos_nxt;
                win_last_q  <= bus.eop_i;
            end else if (win_valid_q && bus.win_ready_i) begin
                win_q       <= '0;
                win_valid_q <= 1'b0;
            end
            drop_q <= drop_nxt;
        end
    end
endmodule

// File: doc/str_window.md
Name: str_window

Overview:
- Upstream feeder for the CRC hash stage of the bloom filter.
- Turns a packetised byte stream into a sliding window of STR_SIZE bytes, one window per accepted byte once the window is full.
- Each window carries its byte offset, so a downstream match can be located in the packet.
- Window ordering matches the hash's consumption order: element 0 is the oldest byte.

Parameters:
- BYTE_W, 8, width of one byte/symbol.
- STR_SIZE, 20, window length in bytes; must be >= 2.
- POS_W, 16, width of the window offset counter.

Ports:
- clk_i  input  1  clock.
- rst_n_i  input  1  asynchronous active-low reset.
- data_i  input  BYTE_W  input byte.
- valid_i  input  1  data_i, sop_i and eop_i are valid.
- sop_i  input  1  first byte of packet.
- eop_i  input  1  last byte of packet.
- ready_o  output  1  block accepts a byte this cycle.
- win_o  output  STR_SIZE x BYTE_W  packed window; [0] is oldest, [STR_SIZE-1] is newest.
- win_valid_o  output  1  window valid.
- win_ready_i  input  1  downstream accepts the window.
- win_pos_o  output  POS_W  packet offset of win_o[0].
- win_last_o  output  1  window was completed by the eop byte.
- drop_o  output  1  one-cycle pulse: a packet ended without producing any window.

Behaviour:
- Reset (async assert, sync release): win_valid_o, win_last_o, drop_o and win_pos_o are 0; win_o is all zero; fill is 0; state is IDLE.
- ready_o = !win_valid_o || win_ready_i, combinational, so it is 1 during and after reset.
- Accept: a byte is accepted when valid_i && ready_o.
- States: IDLE (outside a packet) and IN_PKT.
  - IDLE: an accepted byte without sop_i is discarded with no effect.
  - IDLE -> IN_PKT on an accepted byte with sop_i.
  - IN_PKT -> IDLE on an accepted byte with eop_i.
- Shift on accept in IN_PKT, or on an accepted sop byte:
  - win[k] <= win[k+1] for k < STR_SIZE-1; win[STR_SIZE-1] <= data_i.
- Fill counter:
  - sop byte: fill <= 1 and the packet's emitted flag clears.
  - Any other accepted byte: fill increments, saturating at STR_SIZE.
  - Bytes in win_o below index STR_SIZE-fill are stale and never visible while win_valid_o is 1.
- Emit: when an accepted byte brings fill to STR_SIZE, or arrives with fill already STR_SIZE:
  - win_valid_o is 1 on the next cycle with the shifted window (latency 1).
  - The emitted flag sets.
  - win_pos_o = 0 for the first window of a packet, then +1 per window, saturating at 2^POS_W-1.
  - win_last_o = eop_i of that byte.
- Handshake:
  - The window register is cleared when win_valid_o && win_ready_i and no new window is loaded that cycle.
  - If a window is consumed and a new one loaded in the same cycle, win_valid_o stays 1 (full throughput, one byte per cycle).
  - While win_valid_o && !win_ready_i: ready_o is 0 and win_o, win_pos_o, win_last_o are held stable.
- sop_i while IN_PKT: the old packet is aborted and the byte restarts as a new packet (fill=1, pos=0).
  - If the aborted packet emitted nothing, drop_o pulses.
- eop_i with the emitted flag still 0 (short packet, including sop&&eop on one byte): no window; drop_o pulses the cycle after the accept.
- drop_o timing: registered, exactly one cycle wide, independent of win_ready_i.
- Reset mid-packet: all state is discarded immediately; no window or drop_o is produced for the interrupted packet.
- Last window stays valid after eop until consumed; the next packet's sop byte is not accepted until then (ready_o is 0).

Test Plan:
- STR_SIZE=4, win_ready_i=1, packet 0x41..0x46 (sop on 0x41, eop on 0x46) -> three windows on consecutive cycles:
  - 41 42 43 44, pos 0;
  - 42 43 44 45, pos 1;
  - 43 44 45 46, pos 2, win_last_o=1.
  - First window appears one cycle after 0x44 is accepted; drop_o stays 0.
- STR_SIZE=4, 3-byte packet 0x10 0x11 0x12 -> no win_valid_o; drop_o=1 for exactly one cycle after the eop accept.
  - Single-byte sop&&eop packet -> same drop_o pulse.
- Same 6-byte packet with win_ready_i held 0 for 5 cycles after the first window -> ready_o=0 and win_o/win_pos_o stable throughout.
  - After release, the remaining windows arrive in order; no byte is lost or duplicated.
- sop_i on the 3rd byte of a packet, then 4 more bytes A0..A3 with eop -> drop_o pulse at the restart.
  - Single window A0 A1 A2 A3, pos 0, win_last_o=1.
- Bytes with valid_i=1 but no sop_i after reset -> ignored, no outputs.
  - Assert rst_n_i low mid-packet while win_valid_o=1 -> win_valid_o=0 immediately; the next sop starts cleanly at pos 0.
- POS_W=2, 10-byte packet with STR_SIZE=4 -> win_pos_o runs 0,1,2,3,3,3,3 (saturates at 3).
